rtc_field_adjuster: RTL
=======================

Name: rtc_field_adjuster

Overview:
- Parametrised time/date field editor for the RTC setting path.
- Captures one field value read from the RTC, steps it up/down from debounced push buttons with range wrap-around, optional BCD arithmetic and hold-to-auto-repeat, then presents the committed value for write-back.
- Sits between the push-button debouncers and the RTC write controller; one instance per editable field (seconds, minutes, hours, day, ...).

Parameters:
- WIDTH, 8, field width in bits.
- BCD, 1, 1 = packed two-digit BCD arithmetic (requires WIDTH=8); 0 = plain unsigned binary.
- MIN_VAL, 0, lowest legal value, in the encoding selected by BCD.
- MAX_VAL, 8'h59, highest legal value, in the encoding selected by BCD.
- REPEAT_DLY, 8, tick strobes a direction must be held before auto-repeat starts.
- REPEAT_RATE, 2, tick strobes between auto-repeat steps.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  editing session active; low forces IDLE.
- load  in  1  one-cycle strobe: capture dato_rtc into the working value.
- dato_rtc  in  WIDTH  field value read from the RTC.
- push  in  2  debounced buttons: 01 = decrement, 10 = increment, 00/11 = none.
- tick  in  1  one-cycle timebase strobe for auto-repeat.
- commit  in  1  one-cycle strobe: publish the working value.
- dato  out  WIDTH  last committed value.
- edit_val  out  WIDTH  current working value.
- dato_valid  out  1  one-cycle pulse when dato is updated.
- editing  out  1  high in EDIT state.

Behaviour:
- Reset (asynchronous, immediate): dato=0, edit_val=0, dato_valid=0, editing=0, state=IDLE, repeat counter=0, registered previous push=00.
- States: IDLE, EDIT, COMMIT.
  - IDLE -> EDIT on load while enable=1.
  - EDIT -> COMMIT on commit.
  - COMMIT -> IDLE unconditionally after one cycle.
  - Any state -> IDLE when enable=0. dato is unchanged and no dato_valid pulse occurs.
- Load: on the next clock edge edit_val <= dato_rtc. Sanitisation: if dato_rtc < MIN_VAL, > MAX_VAL, or (BCD=1) either nibble > 9, edit_val <= MIN_VAL. load is also accepted in EDIT and re-captures the value.
- Step detection: push is registered each cycle. A press is push in {01,10} differing from the registered previous value. That covers 00->01, 00->10, a direction reversal 01<->10, and 11->01/10. A press applies one step, visible on edit_val one cycle after the push change is sampled.
- Arithmetic:
  - Increment: value == MAX_VAL -> MIN_VAL, else +1.
  - Decrement: value == MIN_VAL -> MAX_VAL, else -1.
  - BCD=1 increment: low nibble 9 -> 0 with carry into the high nibble.
  - BCD=1 decrement: low nibble 0 -> 9 with borrow.
  - The result is always within [MIN_VAL, MAX_VAL] and valid BCD.
- Auto-repeat: while the same direction is held in EDIT, the repeat counter counts tick strobes.
  - When the count reaches REPEAT_DLY, one step is applied and the counter reloads.
  - Thereafter one step every REPEAT_RATE ticks.
  - Release (00/11) or reversal clears the counter.
  - Pushes and ticks are ignored outside EDIT.
- Priority within EDIT for the same cycle: load > commit > step. Any step sampled in that cycle is discarded.
- Commit: the cycle after commit is sampled, dato <= edit_val and dato_valid=1 for exactly one cycle; editing falls in the same cycle. Latency from commit to dato is 1 clock.
- editing is a registered decode of state == EDIT.

Test Plan:
- Reset: assert reset mid-EDIT with edit_val=8'h37 -> all outputs 0 immediately (no clock needed); after release, push is ignored until the next load.
- Increment wrap: BCD=1, MAX=8'h59; load 8'h58, two inc presses -> edit_val 8'h59 then 8'h00; commit -> dato=8'h00, dato_valid high exactly 1 cycle.
- Decrement/borrow: load 8'h10, dec -> 8'h09; load 8'h00, dec -> 8'h59. With BCD=0, MIN=1, MAX=12: load 1, dec -> 12.
- Auto-repeat: REPEAT_DLY=8, REPEAT_RATE=2; hold inc from 8'h00 for 12 ticks -> 8'h01 at press, 8'h02 at tick 8, 8'h03 at tick 10, 8'h04 at tick 12; reversal to dec -> immediate 8'h03.
- Sanitise/priority: load 8'h7A -> edit_val=MIN_VAL. Load and commit in the same cycle -> load taken, no dato_valid. Commit and inc press in the same cycle -> dato equals the pre-step value.
- Abort: dato=8'h15 committed earlier; new session load 8'h30, inc, then enable=0 -> IDLE, dato stays 8'h15, no pulse.

Source files
------------

// File: rtl/rtc_field_adjuster.sv
// ----------------------------------------------------------------------------
// rtc_field_adjuster
//
// Editor for a single RTC time/date field. A value read back from the RTC is
// captured into a working register, stepped up or down from the debounced push
// buttons (with wrap-around inside [MIN_VAL, MAX_VAL], optional packed BCD
// arithmetic and hold-to-auto-repeat), and finally published for write-back.
// One instance is used per editable field.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   enable     in   editing session active; low returns to IDLE
//   load       in   one-cycle strobe: capture dato_rtc into the working value
//   dato_rtc   in   field value read from the RTC
//   push       in   debounced buttons: 01 = decrement, 10 = increment
//   tick       in   one-cycle timebase strobe for auto-repeat
//   commit     in   one-cycle strobe: publish the working value
//   dato       out  last committed value
//   edit_val   out  current working value
//   dato_valid out  one-cycle pulse when dato is updated
//   editing    out  high while in the EDIT state
// ----------------------------------------------------------------------------
module rtc_field_adjuster #(
    parameter int WIDTH       = 8,
    parameter int BCD         = 1,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 'h59,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] dato_rtc,
    input  logic [1:0]       push,
    input  logic             tick,
    input  logic             commit,
    output logic [WIDTH-1:0] dato,
    output logic [WIDTH-1:0] edit_val,
    output logic             dato_valid,
    output logic             editing
);

    localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] SPAN_C = WIDTH'(MAX_VAL - MIN_VAL);
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(RPT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_C      = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] RATE_C     = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EDIT   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_edit_val;
    logic [WIDTH-1:0]   r_dato;
    logic               r_dato_valid;
    logic               r_editing;
    logic [1:0]         r_push_prev;
    logic [CNT_W-1:0]   r_rpt_cnt;
    logic               r_rpt_phase;

    logic               w_dir_valid;
    logic               w_press;
    logic               w_held;
    logic               w_in_edit;
    logic               w_do_load;
    logic               w_do_commit;
    logic               w_rpt_fire;
    logic               w_step;
    logic               w_step_up;
    logic [CNT_W-1:0]   w_rpt_limit;
    logic [CNT_W-1:0]   w_rpt_next;
    logic               w_in_range;
    logic               w_load_ok;
    logic [WIDTH-1:0]   w_inc_val;
    logic [WIDTH-1:0]   w_dec_val;

    // Range test folded into a single unsigned compare: values below MIN_VAL
    // wrap around to large numbers after the subtraction and fall out of span.
    assign w_in_range = ((dato_rtc - MIN_C) <= SPAN_C);

    // Encoding-specific arithmetic and load sanitisation. Both step results
    // are computed for the current working value, which is always legal.
    generate
        if (BCD != 0) begin : g_bcd
            assign w_load_ok = w_in_range && (dato_rtc[3:0] <= 4'd9) && (dato_rtc[7:4] <= 4'd9);
            assign w_inc_val = (r_edit_val == MAX_C) ? MIN_C :
                               (r_edit_val[3:0] == 4'd9) ? {r_edit_val[7:4] + 4'd1, 4'd0} :
                               (r_edit_val + ONE_C);
            assign w_dec_val = (r_edit_val == MIN_C) ? MAX_C :
                               (r_edit_val[3:0] == 4'd0) ? {r_edit_val[7:4] - 4'd1, 4'd9} :
                               (r_edit_val - ONE_C);
        end else begin : g_bin
            assign w_load_ok = w_in_range;
            assign w_inc_val = (r_edit_val == MAX_C) ? MIN_C : (r_edit_val + ONE_C);
            assign w_dec_val = (r_edit_val == MIN_C) ? MAX_C : (r_edit_val - ONE_C);
        end
    endgenerate

    // Button decode. A press is a new direction compared to last cycle's
    // sample; a hold is the same direction seen twice in a row.
    assign w_dir_valid = (push == 2'b01) || (push == 2'b10);
    assign w_press     = w_dir_valid && (push != r_push_prev);
    assign w_held      = w_dir_valid && (push == r_push_prev);
    assign w_step_up   = (push == 2'b10);

    // Load outranks commit, which outranks any step in the same cycle.
    assign w_in_edit   = enable && (r_state == EDIT);
    assign w_do_load   = enable && load && ((r_state == IDLE) || (r_state == EDIT));
    assign w_do_commit = w_in_edit && commit && !load;

    // The first auto-repeat step waits REPEAT_DLY ticks; later steps wait
    // REPEAT_RATE ticks. r_rpt_phase records which interval is running.
    assign w_rpt_limit = r_rpt_phase ? RATE_C : DLY_C;
    assign w_rpt_next  = r_rpt_cnt + CNT_ONE_C;
    assign w_rpt_fire  = w_in_edit && w_held && tick && (w_rpt_next == w_rpt_limit);
    assign w_step      = w_in_edit && !load && !commit && (w_press || w_rpt_fire);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; dropping enable overrides every transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load) w_next_state = EDIT;
            EDIT:    if (!load && commit) w_next_state = COMMIT;
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if (!enable) begin
            w_next_state = IDLE;
        end
    end

    // Working value, committed value and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edit_val   <= '0;
            r_dato       <= '0;
            r_dato_valid <= 1'b0;
            r_editing    <= 1'b0;
            r_push_prev  <= 2'b00;
        end else begin
            r_push_prev  <= push;
            r_dato_valid <= 1'b0;
            r_editing    <= (w_next_state == EDIT);
            if (w_do_load) begin
                r_edit_val <= w_load_ok ? dato_rtc : MIN_C;
            end else if (w_do_commit) begin
                r_dato       <= r_edit_val;
                r_dato_valid <= 1'b1;
            end else if (w_step) begin
                r_edit_val <= w_step_up ? w_inc_val : w_dec_val;
            end
        end
    end

    // Auto-repeat tick counter. Anything other than a steady hold in EDIT
    // (release, reversal, fresh press, load, commit, leaving EDIT) restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (!w_in_edit || load || commit || !w_held) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else if (tick) begin
            if (w_rpt_fire) begin
                r_rpt_cnt   <= '0;
                r_rpt_phase <= 1'b1;
            end else begin
                r_rpt_cnt <= w_rpt_next;
            end
        end
    end

    assign dato       = r_dato;
    assign edit_val   = r_edit_val;
    assign dato_valid = r_dato_valid;
    assign editing    = r_editing;

endmodule
